// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default sizing and the
// controller state encoding.
package div_pkg;

    // Default operand width and the iteration counter width that goes with it.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    // Controller states. CALC runs one restoring step per cycle, FIX applies
    // the operand signs, DONE emits the completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle for the restoring divider. The master side issues a
// division request and observes the result; the slave side is the divider.
interface restoring_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    // Request, sampled by the divider only while it is idle.
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;

    // Status and results, all registered inside the divider.
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left,
// bringing in the next dividend bit, then trial-subtract the divisor
// magnitude. A non-negative difference is kept and yields a quotient bit of
// 1; otherwise the shifted remainder is restored and the quotient bit is 0.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             quo_bit
);

    // One extra bit beyond the remainder width so the sign of the trial
    // difference is never ambiguous.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             neg;

    assign shifted = {rem_in, next_bit};
    assign diff    = shifted - {2'b00, divisor};
    assign neg     = diff[WIDTH+1];

    assign quo_bit = ~neg;
    assign rem_out = neg ? shifted[WIDTH:0] : diff[WIDTH:0];

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, signed or unsigned per request.
// Operands are converted to magnitudes on acceptance, divided over WIDTH
// single-step cycles, and the signs are re-applied in one fix-up cycle:
// the quotient truncates toward zero and the remainder takes the dividend's
// sign. A zero divisor short-circuits straight to completion with an
// all-ones quotient, the dividend as remainder, and div_by_zero raised.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    restoring_divider_if.slave  bus
);

    // Controller and datapath state.
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_q;      // partial remainder, one guard bit wide
    logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic             q_neg;      // operand signs differ
    logic             r_neg;      // dividend was negative

    // Registered outputs.
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    // Operand sign and magnitude, evaluated on the live request inputs.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Single-step datapath results.
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;

    // Magnitudes of the incoming operands. The most negative value maps to
    // itself, which is exactly its magnitude when read as unsigned.
    assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign b_mag = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in   (rem_q),
        .next_bit (quo_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_out  (rem_nxt),
        .quo_bit  (q_bit)
    );

    // Controller, iteration datapath and registered outputs in one process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side below sees the value from before this edge.
            done_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            // Nothing to iterate: publish the fixed result now.
                            dbz_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            state       <= DONE;
                        end else begin
                            dbz_q  <= 1'b0;
                            q_neg  <= a_neg ^ b_neg;
                            r_neg  <= a_neg;
                            quo_q  <= a_mag;
                            dvs_q  <= b_mag;
                            rem_q  <= '0;
                            cnt    <= CNT_W'(WIDTH - 1);
                            busy_q <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                FIX: begin
                    // Remainder magnitude is below the divisor, so the guard
                    // bit is zero here and only the low WIDTH bits matter.
                    quotient_q  <= q_neg ? (~quo_q + 1'b1) : quo_q;
                    remainder_q <= r_neg ? (~rem_q[WIDTH-1:0] + 1'b1)
                                         : rem_q[WIDTH-1:0];
                    busy_q      <= 1'b0;
                    state       <= DONE;
                end

                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for the restoring divider: reset state, latency and busy
// length, unsigned and signed arithmetic, divide-by-zero, ignored start,
// result hold and reset in the middle of a calculation.
module tb_restoring_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    restoring_divider_if #(.WIDTH(W)) bus ();

    restoring_divider #(
        .WIDTH (W),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string        name;
        bit           sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t unsigned_tbl [4] = '{
        '{"u_max_by_1",    1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000},
        '{"u_small_by_big",1'b0, 32'h0000_0005, 32'h0000_0009, 32'h0000_0000, 32'h0000_0005},
        '{"u_min_by_max",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
        '{"u_max_by_64k",  1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF}
    };

    vec_t signed_tbl [5] = '{
        '{"s_neg100_by_7",  1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 32'hFFFF_FFFE},
        '{"s_100_by_neg7",  1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002},
        '{"s_neg100_by_neg7",1'b1,32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE},
        '{"s_7_by_neg100",  1'b1, 32'h0000_0007, 32'hFFFF_FF9C, 32'h0000_0000, 32'h0000_0007},
        '{"s_min_by_neg1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000}
    };

    // Issue one request, scramble the operand inputs right after acceptance,
    // optionally pulse a second start after inject_at cycles, and wait (bounded)
    // for done. lat counts edges after the accepting edge up to the done sample.
    task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dbz, output int lat, output int busy_cnt,
                          output logic done_after);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.signed_op = ~sgn;
        bus.dividend  = ~a;
        bus.divisor   = b ^ 32'h5A5A_0003;
        lat      = 0;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == inject_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd9;
                bus.divisor  = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        bus.start = 1'b0;
        q   = bus.quotient;
        r   = bus.remainder;
        dbz = bus.div_by_zero;
        @(posedge clk);
        #1;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #12;
        n_vec++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++;
        if (bus.quotient !== 32'h0) begin n_bad++; $display("FAIL reset_quotient: got %h want 0", bus.quotient); end
        n_vec++;
        if (bus.remainder !== 32'h0) begin n_bad++; $display("FAIL reset_remainder: got %h want 0", bus.remainder); end
        n_vec++;
        if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
        #10;
        reset = 1'b0;   // mid-cycle; the next rising edge must accept a start
    endtask

    task automatic test_latency();
        logic [W-1:0] q, r;
        logic         dbz, da;
        int           lat, bc;
        run_op(1'b0, 32'd100, 32'd7, -1, q, r, dbz, lat, bc, da);
        n_vec++;
        if (q !== 32'd14) begin n_bad++; $display("FAIL lat_100_7 quotient: got %h want %h", q, 32'd14); end
        n_vec++;
        if (r !== 32'd2) begin n_bad++; $display("FAIL lat_100_7 remainder: got %h want %h", r, 32'd2); end
        n_vec++;
        if (dbz !== 1'b0) begin n_bad++; $display("FAIL lat_100_7 dbz: got %b want 0", dbz); end
        n_vec++;
        if (lat != 34) begin n_bad++; $display("FAIL lat_100_7 latency: got %0d want 34", lat); end
        n_vec++;
        if (bc != 33) begin n_bad++; $display("FAIL lat_100_7 busy_cycles: got %0d want 33", bc); end
        n_vec++;
        if (da !== 1'b0) begin n_bad++; $display("FAIL lat_100_7 done_width: got %b want 0", da); end
    endtask

    task automatic test_unsigned();
        logic [W-1:0] q, r;
        logic         dbz, da;
        int           lat, bc;
        foreach (unsigned_tbl[i]) begin
            run_op(unsigned_tbl[i].sgn, unsigned_tbl[i].a, unsigned_tbl[i].b, -1, q, r, dbz, lat, bc, da);
            n_vec++;
            if (q !== unsigned_tbl[i].q) begin
                n_bad++; $display("FAIL %s quotient: got %h want %h", unsigned_tbl[i].name, q, unsigned_tbl[i].q);
            end
            n_vec++;
            if (r !== unsigned_tbl[i].r) begin
                n_bad++; $display("FAIL %s remainder: got %h want %h", unsigned_tbl[i].name, r, unsigned_tbl[i].r);
            end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] q, r;
        logic         dbz, da;
        int           lat, bc;
        foreach (signed_tbl[i]) begin
            run_op(signed_tbl[i].sgn, signed_tbl[i].a, signed_tbl[i].b, -1, q, r, dbz, lat, bc, da);
            n_vec++;
            if (q !== signed_tbl[i].q) begin
                n_bad++; $display("FAIL %s quotient: got %h want %h", signed_tbl[i].name, q, signed_tbl[i].q);
            end
            n_vec++;
            if (r !== signed_tbl[i].r) begin
                n_bad++; $display("FAIL %s remainder: got %h want %h", signed_tbl[i].name, r, signed_tbl[i].r);
            end
            n_vec++;
            if (dbz !== 1'b0) begin
                n_bad++; $display("FAIL %s dbz: got %b want 0", signed_tbl[i].name, dbz);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        logic         dbz, da;
        int           lat, bc;
        run_op(1'b0, 32'h0000_1234, 32'h0, -1, q, r, dbz, lat, bc, da);
        n_vec++;
        if (lat != 1) begin n_bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_vec++;
        if (q !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_quotient: got %h want ffffffff", q); end
        n_vec++;
        if (r !== 32'h0000_1234) begin n_bad++; $display("FAIL dz_remainder: got %h want 00001234", r); end
        n_vec++;
        if (dbz !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b want 1", dbz); end
        n_vec++;
        if (bc != 0) begin n_bad++; $display("FAIL dz_busy_cycles: got %0d want 0", bc); end
        n_vec++;
        if (bus.div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dz_flag_hold: got %b want 1", bus.div_by_zero); end

        run_op(1'b0, 32'd9, 32'd3, -1, q, r, dbz, lat, bc, da);
        n_vec++;
        if (q !== 32'd3) begin n_bad++; $display("FAIL dz_clear quotient: got %h want 3", q); end
        n_vec++;
        if (r !== 32'd0) begin n_bad++; $display("FAIL dz_clear remainder: got %h want 0", r); end
        n_vec++;
        if (dbz !== 1'b0) begin n_bad++; $display("FAIL dz_clear flag: got %b want 0", dbz); end

        run_op(1'b1, 32'hFFFF_FF00, 32'h0, -1, q, r, dbz, lat, bc, da);
        n_vec++;
        if (r !== 32'hFFFF_FF00) begin n_bad++; $display("FAIL dz_signed remainder: got %h want ffffff00", r); end
        n_vec++;
        if (dbz !== 1'b1) begin n_bad++; $display("FAIL dz_signed flag: got %b want 1", dbz); end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] q, r;
        logic         dbz, da;
        int           lat, bc;
        int           busy_seen;
        run_op(1'b0, 32'd100, 32'd7, 5, q, r, dbz, lat, bc, da);
        n_vec++;
        if (q !== 32'd14) begin n_bad++; $display("FAIL ign quotient: got %h want %h", q, 32'd14); end
        n_vec++;
        if (r !== 32'd2) begin n_bad++; $display("FAIL ign remainder: got %h want %h", r, 32'd2); end
        n_vec++;
        if (lat != 34) begin n_bad++; $display("FAIL ign latency: got %0d want 34", lat); end
        n_vec++;
        if (da !== 1'b0) begin n_bad++; $display("FAIL ign done_width: got %b want 0", da); end
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) busy_seen++;
        end
        n_vec++;
        if (busy_seen != 0) begin n_bad++; $display("FAIL ign no_queue: got %0d active cycles want 0", busy_seen); end
        n_vec++;
        if (bus.quotient !== 32'd14) begin n_bad++; $display("FAIL ign hold_quotient: got %h want %h", bus.quotient, 32'd14); end
        n_vec++;
        if (bus.remainder !== 32'd2) begin n_bad++; $display("FAIL ign hold_remainder: got %h want %h", bus.remainder, 32'd2); end
    endtask

    task automatic test_reset_mid_calc();
        logic [W-1:0] q, r;
        logic         dbz, da;
        int           lat, bc;
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset busy: got %b want 0", bus.busy); end
        n_vec++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mid_reset done: got %b want 0", bus.done); end
        n_vec++;
        if (bus.quotient !== 32'h0) begin n_bad++; $display("FAIL mid_reset quotient: got %h want 0", bus.quotient); end
        n_vec++;
        if (bus.remainder !== 32'h0) begin n_bad++; $display("FAIL mid_reset remainder: got %h want 0", bus.remainder); end
        #1;
        reset = 1'b0;
        run_op(1'b0, 32'd50, 32'd5, -1, q, r, dbz, lat, bc, da);
        n_vec++;
        if (q !== 32'd10) begin n_bad++; $display("FAIL post_reset quotient: got %h want %h", q, 32'd10); end
        n_vec++;
        if (r !== 32'd0) begin n_bad++; $display("FAIL post_reset remainder: got %h want 0", r); end
        n_vec++;
        if (lat != 34) begin n_bad++; $display("FAIL post_reset latency: got %0d want 34", lat); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ignore_start();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CNT_W, default 5, iteration counter width; SHALL equal $clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 dividend  input  WIDTH  numerator; sampled with start.
REQ-008 divisor  input  WIDTH  denominator; sampled with start.
REQ-009 busy  output  1  high in CALC and FIX.
REQ-010 done  output  1  one-cycle pulse, results valid.
REQ-011 quotient  output  WIDTH  result quotient.
REQ-012 remainder  output  WIDTH  result remainder.
REQ-013 div_by_zero  output  1  set when the accepted divisor was zero.

Function
REQ-014 FSM states: IDLE, CALC, FIX, DONE; encoded in a typedef enum.
REQ-015 IDLE: start=1 at edge E0 latches operands, records signs if signed_op, loads magnitudes, clears partial remainder, counter=WIDTH-1, next CALC.
REQ-016 CALC: one restoring step per cycle (shift remainder:quotient left 1, trial-subtract divisor magnitude, keep if non-negative, quotient LSB = not negative); exactly WIDTH cycles, counter decrements, leaves to FIX when counter=0.
REQ-017 FIX: applies signs; quotient negated if operand signs differ, remainder negated if dividend negative; registers quotient/remainder; next DONE.
REQ-018 DONE: done=1 for exactly one cycle; next IDLE unconditionally.
REQ-019 Latency: done high in the cycle after edge E0+WIDTH+2 (34 edges for WIDTH=32).
REQ-020 Arithmetic: partial remainder WIDTH+1 bits; signed quotient truncates toward zero; remainder sign follows dividend; |remainder| < |divisor|.
REQ-021 Signed MIN / -1: quotient = MIN (wraps), remainder = 0, no flag.
REQ-022 Divisor zero at E0: skip CALC/FIX, go to DONE at E0+1; quotient all ones, remainder = dividend, div_by_zero=1.
REQ-023 div_by_zero cleared when a non-zero-divisor start is accepted.
REQ-024 start while busy or in DONE SHALL be ignored; no queuing.
REQ-025 quotient, remainder, div_by_zero hold last result until the next accepted start.
REQ-026 Operand changes after E0 SHALL not affect the in-flight result.

Reset
REQ-027 reset asserted at any time (including mid-CALC) forces IDLE immediately, without waiting for clk.
REQ-028 Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal registers 0.
REQ-029 First start is accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Package div_pkg holds the FSM state typedef enum and default WIDTH/CNT_W constants.
REQ-031 One combinational sub-module div_step implements a single shift/trial-subtract iteration (WIDTH+1-bit remainder in/out, quotient bit out); FSM, counter and sign fixup remain in restoring_divider.

Verification
REQ-032 Unsigned 100 / 7, WIDTH=32 -> quotient 14, remainder 2, done at edge E0+34, busy high for 33 cycles.
REQ-033 Signed -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); signed 100 / -7 -> -14, remainder 2.
REQ-034 Divisor 0, dividend 0x1234 -> done at E0+1, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1; next 9/3 clears flag, result 3 remainder 0.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero=0; unsigned 0xFFFFFFFF / 1 -> 0xFFFFFFFF, remainder 0.
REQ-036 start pulsed at cycle 5 of CALC with new operands -> ignored, original result unchanged, single done pulse.
REQ-037 reset asserted mid-CALC between clock edges -> busy, done, outputs 0 before the next edge; a fresh 50 / 5 then yields 10, remainder 0, at normal latency.
